// File: rtl/mem_bus_arbiter.sv
// Shares one external asynchronous-style memory bus between a CPU and a DMA port.
// Each access is setup / strobe (WAIT+1 cycles) / finish, with all bus controls registered.
module mem_bus_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int WAIT    = 1,
    parameter int DMA_PRI = 0
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_ack_o,
    output logic [DW-1:0] cpu_rdata_o,

    input  logic          dma_req_i,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [DW-1:0] dma_wdata_i,
    output logic          dma_ack_o,
    output logic [DW-1:0] dma_rdata_o,

    output logic [AW-1:0] address_o,
    inout  wire  [DW-1:0] data_io,
    output logic          rd_o,
    output logic          wr_o,
    output logic          busy_o,
    output logic          owner_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    logic [1:0]    state_q,      state_d;
    logic [3:0]    cnt_q,        cnt_d;
    logic          we_q,         we_d;
    logic [DW-1:0] wdata_q,      wdata_d;
    logic [AW-1:0] address_q,    address_d;
    logic          owner_q,      owner_d;
    logic          last_owner_q, last_owner_d;
    logic          rd_q,         rd_d;
    logic          wr_q,         wr_d;
    logic          oe_q,         oe_d;
    logic          cpu_ack_q,    cpu_ack_d;
    logic          dma_ack_q,    dma_ack_d;
    logic [DW-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q,  dma_rdata_d;
    logic          grant_dma;

    // Round-robin favours the port that did not win last; DMA_PRI overrides it.
    always_comb begin
        grant_dma = dma_req_i && (!cpu_req_i || (DMA_PRI != 0) || !last_owner_q);
    end

    // Strobes and the data enable are computed from the next state so they
    // leave the flops directly and cannot glitch.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        address_d    = address_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        oe_d         = oe_q;
        cpu_ack_d    = 1'b0;
        dma_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_i || dma_req_i) begin
                    owner_d      = grant_dma;
                    last_owner_d = grant_dma;
                    address_d    = grant_dma ? dma_addr_i  : cpu_addr_i;
                    we_d         = grant_dma ? dma_we_i    : cpu_we_i;
                    wdata_d      = grant_dma ? dma_wdata_i : cpu_wdata_i;
                    oe_d         = grant_dma ? dma_we_i    : cpu_we_i;
                    state_d      = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = WAIT_CNT;
                rd_d    = we_q;
                wr_d    = !we_q;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rd_d    = 1'b1;
                    wr_d    = 1'b1;
                    state_d = S_FINISH;
                    if (owner_q) dma_ack_d = 1'b1;
                    else         cpu_ack_d = 1'b1;
                    if (!we_q) begin
                        if (owner_q) dma_rdata_d = data_io;
                        else         cpu_rdata_d = data_io;
                    end
                end
            end
            S_FINISH: begin
                oe_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Async reset releases the bus at once; an in-flight access is abandoned without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            address_q    <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            rd_q         <= 1'b1;
            wr_q         <= 1'b1;
            oe_q         <= 1'b0;
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            address_q    <= address_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            oe_q         <= oe_d;
            cpu_ack_q    <= cpu_ack_d;
            dma_ack_q    <= dma_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign data_io     = oe_q ? wdata_q : {DW{1'bz}};
    assign address_o   = address_q;
    assign rd_o        = rd_q;
    assign wr_o        = wr_q;
    assign busy_o      = (state_q != S_IDLE);
    assign owner_o     = owner_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign dma_ack_o   = dma_ack_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dma_rdata_o = dma_rdata_q;

    a_strobe_exclusive: assert property (@(posedge clk) disable iff (!rst_n) (rd_q || wr_q));
    a_ack_exclusive:    assert property (@(posedge clk) disable iff (!rst_n) !(cpu_ack_q && dma_ack_q));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: three arbiters (WAIT=1 round-robin, WAIT=1 DMA priority, WAIT=0)
// share one stimulus set; each test checks the instance it targets.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;

    tri1  [7:0]  bus0, bus1, bus2;
    logic        cpu_ack0, dma_ack0, rd0, wr0, busy0, owner0;
    logic        cpu_ack1, dma_ack1, rd1, wr1, busy1, owner1;
    logic        cpu_ack2, dma_ack2, rd2, wr2, busy2, owner2;
    logic [7:0]  cpu_rdata0, dma_rdata0, cpu_rdata1, dma_rdata1, cpu_rdata2, dma_rdata2;
    logic [15:0] addr0, addr1, addr2;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Memory models: a writable array on instance 0, address-derived read data elsewhere.
    logic [7:0] mem0 [0:1023];
    assign bus0 = rd0 ? 8'hzz : mem0[addr0[9:0]];
    always @(posedge wr0) mem0[addr0[9:0]] = bus0;
    assign bus1 = rd1 ? 8'hzz : pat(addr1);
    assign bus2 = rd2 ? 8'hzz : pat(addr2);

    mem_bus_arbiter #(.AW(16), .DW(8), .WAIT(1), .DMA_PRI(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_ack_o(cpu_ack0), .cpu_rdata_o(cpu_rdata0),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
        .dma_ack_o(dma_ack0), .dma_rdata_o(dma_rdata0),
        .address_o(addr0), .data_io(bus0), .rd_o(rd0), .wr_o(wr0), .busy_o(busy0), .owner_o(owner0)
    );

    mem_bus_arbiter #(.AW(16), .DW(8), .WAIT(1), .DMA_PRI(1)) u_pri (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_ack_o(cpu_ack1), .cpu_rdata_o(cpu_rdata1),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
        .dma_ack_o(dma_ack1), .dma_rdata_o(dma_rdata1),
        .address_o(addr1), .data_io(bus1), .rd_o(rd1), .wr_o(wr1), .busy_o(busy1), .owner_o(owner1)
    );

    mem_bus_arbiter #(.AW(16), .DW(8), .WAIT(0), .DMA_PRI(0)) u_w0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_ack_o(cpu_ack2), .cpu_rdata_o(cpu_rdata2),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
        .dma_ack_o(dma_ack2), .dma_rdata_o(dma_rdata2),
        .address_o(addr2), .data_io(bus2), .rd_o(rd2), .wr_o(wr2), .busy_o(busy2), .owner_o(owner2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #50000;
        check("watchdog", 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rd_addrs [3];
        rd_addrs[0] = 16'h0001;
        rd_addrs[1] = 16'h0ABC;
        rd_addrs[2] = 16'hF00F;

        for (int i = 0; i < 1024; i++) mem0[i] = pat(16'(i));
        mem0[16'h0010] = 8'h3C;

        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        #12;
        check("rst_rd",        rd0,        1);
        check("rst_wr",        wr0,        1);
        check("rst_addr",      addr0,      0);
        check("rst_data_z",    bus0,       8'hFF);
        check("rst_busy",      busy0,      0);
        check("rst_owner",     owner0,     0);
        check("rst_acks",      {cpu_ack0, dma_ack0}, 0);
        check("rst_rdata",     {cpu_rdata0, dma_rdata0}, 0);
        rst_n = 1'b1;
        step();

        // Test 1: CPU read of 0x0010, WAIT=1.
        cpu_we = 0; cpu_addr = 16'h0010; cpu_req = 1;
        step();
        check("t1_setup_busy",  busy0, 1);
        check("t1_setup_rd",    rd0,   1);
        check("t1_setup_addr",  addr0, 16'h0010);
        check("t1_setup_owner", owner0, 0);
        cpu_addr = 16'h0055;
        step();
        check("t1_c2_rd",       rd0,   0);
        check("t1_c2_addr",     addr0, 16'h0010);
        step();
        check("t1_c3_rd",       rd0,   0);
        check("t1_c3_ack",      cpu_ack0, 0);
        step();
        check("t1_c4_rd",       rd0,   1);
        check("t1_c4_ack",      cpu_ack0, 1);
        check("t1_c4_dma_ack",  dma_ack0, 0);
        check("t1_rdata",       cpu_rdata0, 8'h3C);
        cpu_req = 0;
        step();
        check("t1_ack_drop",    cpu_ack0, 0);
        check("t1_idle",        busy0, 0);
        check("t1_addr_hold",   addr0, 16'h0010);

        // Test 2: DMA write 0x0200 <- 0xA5, request dropped mid-transaction.
        dma_we = 1; dma_addr = 16'h0200; dma_wdata = 8'hA5; dma_req = 1;
        step();
        check("t2_setup_data",  bus0,  8'hA5);
        check("t2_setup_wr",    wr0,   1);
        check("t2_owner",       owner0, 1);
        dma_req = 0; dma_wdata = 8'h11;
        step();
        check("t2_c2_wr",       wr0,   0);
        check("t2_c2_rd",       rd0,   1);
        check("t2_c2_data",     bus0,  8'hA5);
        step();
        check("t2_c3_wr",       wr0,   0);
        check("t2_no_commit",   mem0[16'h0200], pat(16'h0200));
        step();
        check("t2_c4_wr",       wr0,   1);
        check("t2_c4_data",     bus0,  8'hA5);
        check("t2_commit",      mem0[16'h0200], 8'hA5);
        check("t2_ack",         dma_ack0, 1);
        check("t2_cpu_ack",     cpu_ack0, 0);
        check("t2_rdata_keep",  {cpu_rdata0, dma_rdata0}, {8'h3C, 8'h00});
        step();
        check("t2_data_z",      bus0,  8'hFF);
        check("t2_ack_drop",    dma_ack0, 0);

        // Tests 3 and 4: both ports requesting; round-robin vs DMA priority.
        pulse_reset();
        step();
        dma_we = 0; cpu_addr = 16'h0123; dma_addr = 16'h0345;
        cpu_req = 1; dma_req = 1;
        for (int t = 0; t < 4; t++) begin
            step();
            check($sformatf("t3_owner_%0d", t), owner0, 32'(t % 2));
            check($sformatf("t4_owner_%0d", t), owner1, 1);
            step();
            step();
            step();
            check($sformatf("t3_acks_%0d", t), {cpu_ack0, dma_ack0}, (t % 2 == 0) ? 2'b10 : 2'b01);
            check($sformatf("t4_acks_%0d", t), {cpu_ack1, dma_ack1}, 2'b01);
            if (t == 3) dma_req = 0;
            step();
            check($sformatf("t3_idle_%0d", t), {busy0, busy1}, 2'b00);
        end
        check("t3_cpu_rdata",   cpu_rdata0, pat(16'h0123));
        check("t3_dma_rdata",   dma_rdata0, pat(16'h0345));
        check("t4_cpu_rdata0",  cpu_rdata1, 8'h00);
        check("t4_dma_rdata",   dma_rdata1, pat(16'h0345));
        step();
        check("t4_cpu_owner",   owner1, 0);
        step();
        step();
        step();
        check("t4_cpu_ack",     {cpu_ack1, dma_ack1}, 2'b10);
        check("t4_cpu_rdata",   cpu_rdata1, pat(16'h0123));
        cpu_req = 0;
        step();

        // Test 5: reset during the second strobe cycle of a CPU write.
        cpu_we = 1; cpu_addr = 16'h0300; cpu_wdata = 8'h77; cpu_req = 1;
        step();
        step();
        step();
        check("t5_strobe2_wr",  wr0, 0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_strobes", {rd0, wr0}, 2'b11);
        check("t5_rst_data_z",  bus0, 8'hFF);
        check("t5_rst_busy",    busy0, 0);
        check("t5_rst_ack",     {cpu_ack0, dma_ack0}, 0);
        #1;
        rst_n = 1'b1;
        cpu_req = 0;
        step();
        check("t5_post_busy",   busy0, 0);
        check("t5_post_ack",    cpu_ack0, 0);
        dma_we = 0; dma_addr = 16'h0010; dma_req = 1;
        step();
        check("t5_dma_owner",   {busy0, owner0}, 2'b11);
        dma_req = 0;
        step();
        step();
        step();
        check("t5_dma_ack",     dma_ack0, 1);
        check("t5_dma_rdata",   dma_rdata0, 8'h3C);
        step();
        check("t5_done",        busy0, 0);

        // Test 6: WAIT=0, three back-to-back CPU reads.
        pulse_reset();
        step();
        cpu_we = 0; cpu_addr = rd_addrs[0]; cpu_req = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t6_setup_%0d", k), {busy2, rd2}, 2'b11);
            step();
            check($sformatf("t6_rd_low_%0d", k), rd2, 0);
            step();
            check($sformatf("t6_rd_high_%0d", k), rd2, 1);
            check($sformatf("t6_ack_%0d", k), cpu_ack2, 1);
            check($sformatf("t6_rdata_%0d", k), cpu_rdata2, pat(rd_addrs[k]));
            if (k < 2) cpu_addr = rd_addrs[k + 1];
            else       cpu_req = 0;
            step();
            check($sformatf("t6_ack_drop_%0d", k), cpu_ack2, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
